sigcorrelate: RTL and testbench
===============================

# sigcorrelate

Time-multiplexed correlator that consumes the framed antenna IQ stream produced by the signal input buffer in the `vis_clk` domain. Each timeslice `taddr_i` selects one antenna pair (A, B) from fixed tap tables. It accumulates `COUNT` 1-bit complex cross-products per pair and emits one partial visibility (real/imag agreement counts) per timeslice to the final-stage accumulators.

## Interface
- `WIDTH`, 32: number of antennas; width of the IQ words.
- `TRATE`, 30: timeslices per frame. `TBITS = $clog2(TRATE)`.
- `LOOP0`, 3 and `LOOP1`, 5: `COUNT = LOOP0*LOOP1` samples per partial sum. `CBITS = $clog2(COUNT)`.
- `ATAPS`, 0: flattened `TRATE*IBITS` vector of A-antenna indices. `IBITS = $clog2(WIDTH)`. Entry t is at `[t*IBITS +: IBITS]`.
- `BTAPS`, 0: same layout, for B-antenna indices.
- `SBITS`, `$clog2(2*COUNT+1)`: sum width (localparam).
- `vis_clk` in 1: the single clock. All logic uses rising edges.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: sample strobe.
- `first_i` in 1: first sample of a frame. Forces a new sum to start.
- `last_i` in 1: final sample of a frame.
- `taddr_i` in TBITS: timeslice of the current sample.
- `idata_i`, `qdata_i` in WIDTH: 1-bit I/Q per antenna. A 1 bit means +1 and a 0 bit means -1.
- `valid_o` out 1: one-cycle strobe when a sum is complete.
- `last_o` out 1: the sum is the last of its frame.
- `taddr_o` out TBITS: timeslice the sum belongs to.
- `re_o`, `im_o` out SBITS: unsigned agreement counts.

## Operation
- Stage 1 registers the following on each `valid_i`:
  - `ai = idata_i[A]`, `aq = qdata_i[A]`, `bi = idata_i[B]`, `bq = qdata_i[B]`, with `A`/`B` looked up from `ATAPS`/`BTAPS` at `taddr_i`.
  - `valid_i`, `first_i`, `last_i`, `taddr_i`.
  - An out-of-range `taddr_i` (≥ TRATE) gives undefined data but must not hang the control logic.
- Term per sample:
  - Real: `rt = (ai ~^ bi) + (aq ~^ bq)`, in 0..2.
  - Imaginary: `it = (aq ~^ bi) + (ai ^ bq)`, in 0..2.
  - The signed value is recovered downstream as `2*sum - 2*COUNT`.
- Sample counter `scnt` (CBITS bits) counts only stage-1-valid samples.
  - On a stage-1 sample with `first` set, or with `scnt == 0`: accumulators load `rt`/`it` (no add), `scnt <= 1`, and the sum's `taddr` is captured.
  - On any other stage-1 sample: the accumulators add the terms and `scnt` increments.
  - When the sample being added is the `COUNT`-th: load `re_o = acc_re + rt`, `im_o = acc_im + it`, `taddr_o` (captured value), and `last_o` (that sample's `last`). Pulse `valid_o`, then set `scnt <= 0`.
- `first` arriving mid-sum discards the partial sum silently; no output is produced for it.
- Gaps (`valid_i` low) freeze the counter and accumulators; there is no timeout.
- `COUNT == 1`: every sample loads and completes in the same cycle.
- Arithmetic: the maximum sum is `2*COUNT`, which fits `SBITS`, so no saturation is needed.

## Timing
- Reset (async assert, sync release): `valid_o=0`, `last_o=0`, `taddr_o=0`, `re_o=0`, `im_o=0`. `scnt=0`, accumulators 0, stage-1 valid 0.
- Latency: `valid_o` is high for exactly one cycle, after the 2nd rising edge following the edge that samples the `COUNT`-th contributing `valid_i`.
- `re_o`, `im_o`, `taddr_o`, `last_o` hold their values until the next completed sum. They are valid only while `valid_o` is high.
- Throughput: one sample per cycle, with no back-pressure. Back-to-back sums produce `valid_o` every `COUNT` cycles.
- `reset_n` asserted mid-sum: the partial sum is discarded and no `valid_o` occurs afterwards. The next sum starts cleanly from the first post-reset sample.

## Test plan
Configuration for all scenarios: WIDTH=4, TRATE=2, LOOP0=2, LOOP1=2 (COUNT=4, SBITS=4). Taps: t0 is (A=0, B=1); t1 is (A=1, B=2).
- **Reset:** hold `reset_n` low with random inputs toggling -> all outputs 0. Release and idle -> `valid_o` stays 0.
- **All-ones:** `idata=qdata=4'b1111`, 4 consecutive valid samples at t0, `first_i` on sample 1 -> one `valid_o`, 2 edges after sample 4, with `re_o=8`, `im_o=4`, `taddr_o=0`.
- **Mixed bits with gaps:** `idata=4'b0001`, `qdata=4'b0000` at t0, with 3 idle cycles between each sample -> `re_o=4`, `im_o=8`. `valid_o` appears 2 edges after the 4th sample.
- **Mid-sum restart:** 2 samples, then `first_i` on the 3rd, then 3 more samples -> exactly one `valid_o`, after the 6th sample, summing only samples 3..6.
- **Full frame:** 4 samples at t0 then 4 at t1, with `last_i` on sample 8 -> two `valid_o` strobes 4 cycles apart, carrying `taddr_o` 0 then 1, with `last_o` 0 then 1.
- **Reset mid-sum:** pulse `reset_n` low after 2 samples -> no `valid_o` is produced for them. 4 further samples yield a correct sum.

Source files
------------

// File: rtl/sigcorrelate.sv
// Time-multiplexed 1-bit complex cross-correlator: per timeslice one antenna pair,
// COUNT samples are folded into real/imag agreement counts and emitted as one partial visibility.
module sigcorrelate #(
   parameter  int WIDTH = 32,
   parameter  int TRATE = 30,
   parameter  int LOOP0 = 3,
   parameter  int LOOP1 = 5,
   parameter  logic [TRATE*$clog2(WIDTH)-1:0] ATAPS = '0,
   parameter  logic [TRATE*$clog2(WIDTH)-1:0] BTAPS = '0,
   localparam int TBITS = $clog2(TRATE),
   localparam int IBITS = $clog2(WIDTH),
   localparam int COUNT = LOOP0 * LOOP1,
   localparam int CBITS = $clog2(COUNT),
   localparam int SBITS = $clog2(2 * COUNT + 1)
) (
   input  logic             vis_clk,
   input  logic             reset_n,
   input  logic             valid_i,
   input  logic             first_i,
   input  logic             last_i,
   input  logic [TBITS-1:0] taddr_i,
   input  logic [WIDTH-1:0] idata_i,
   input  logic [WIDTH-1:0] qdata_i,
   output logic             valid_o,
   output logic             last_o,
   output logic [TBITS-1:0] taddr_o,
   output logic [SBITS-1:0] re_o,
   output logic [SBITS-1:0] im_o
);

   // A COUNT of 1 gives a zero-width counter; keep at least one bit.
   localparam int CW = (CBITS < 1) ? 1 : CBITS;
   localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

   // ---------------- stage 1: tap lookup and bit capture ----------------
   int               tsel;
   logic [IBITS-1:0] a_idx;
   logic [IBITS-1:0] b_idx;

   always_comb begin
      tsel = 0;
      if (int'(taddr_i) < TRATE) tsel = int'(taddr_i);
      a_idx = ATAPS[tsel*IBITS +: IBITS];
      b_idx = BTAPS[tsel*IBITS +: IBITS];
   end

   logic             s1_valid_q, s1_first_q, s1_last_q;
   logic [TBITS-1:0] s1_taddr_q;
   logic             s1_ai_q, s1_aq_q, s1_bi_q, s1_bq_q;

   always_ff @(posedge vis_clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_taddr_q <= '0;
         s1_ai_q    <= 1'b0;
         s1_aq_q    <= 1'b0;
         s1_bi_q    <= 1'b0;
         s1_bq_q    <= 1'b0;
      end else begin
         s1_valid_q <= valid_i;
         s1_first_q <= first_i;
         s1_last_q  <= last_i;
         s1_taddr_q <= taddr_i;
         s1_ai_q    <= idata_i[a_idx];
         s1_aq_q    <= qdata_i[a_idx];
         s1_bi_q    <= idata_i[b_idx];
         s1_bq_q    <= qdata_i[b_idx];
      end
   end

   // ---------------- stage 2: per-sample agreement terms ----------------
   logic [1:0] rt_d, it_d;

   always_comb begin
      rt_d = {1'b0, s1_ai_q ~^ s1_bi_q} + {1'b0, s1_aq_q ~^ s1_bq_q};
      it_d = {1'b0, s1_aq_q ~^ s1_bi_q} + {1'b0, s1_ai_q ^ s1_bq_q};
   end

   logic             s2_valid_q, s2_first_q, s2_last_q;
   logic [TBITS-1:0] s2_taddr_q;
   logic [1:0]       s2_rt_q, s2_it_q;

   always_ff @(posedge vis_clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_taddr_q <= '0;
         s2_rt_q    <= '0;
         s2_it_q    <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         s2_taddr_q <= s1_taddr_q;
         s2_rt_q    <= rt_d;
         s2_it_q    <= it_d;
      end
   end

   // ---------------- stage 3: accumulate and emit ----------------
   logic [CW-1:0]    scnt_q, scnt_d;
   logic [SBITS-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic [TBITS-1:0] sum_taddr_q, sum_taddr_d;
   logic             valid_q, valid_d, last_q, last_d;
   logic [TBITS-1:0] taddr_q, taddr_d;
   logic [SBITS-1:0] re_q, re_d, im_q, im_d;
   logic             start;
   logic [SBITS-1:0] sum_re, sum_im;

   always_comb begin
      scnt_d      = scnt_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      sum_taddr_d = sum_taddr_q;
      valid_d     = 1'b0;
      last_d      = last_q;
      taddr_d     = taddr_q;
      re_d        = re_q;
      im_d        = im_q;
      // A first flag or an idle counter restarts the sum, dropping any partial one.
      start       = s2_first_q || (scnt_q == '0);
      sum_re      = acc_re_q + SBITS'(s2_rt_q);
      sum_im      = acc_im_q + SBITS'(s2_it_q);

      if (s2_valid_q) begin
         if (start) begin
            acc_re_d    = SBITS'(s2_rt_q);
            acc_im_d    = SBITS'(s2_it_q);
            sum_taddr_d = s2_taddr_q;
            scnt_d      = CW'(1);
            if (COUNT == 1) begin
               valid_d = 1'b1;
               last_d  = s2_last_q;
               taddr_d = s2_taddr_q;
               re_d    = SBITS'(s2_rt_q);
               im_d    = SBITS'(s2_it_q);
               scnt_d  = '0;
            end
         end else begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            scnt_d   = scnt_q + CW'(1);
            if (scnt_q == LAST_CNT) begin
               valid_d = 1'b1;
               last_d  = s2_last_q;
               taddr_d = sum_taddr_q;
               re_d    = sum_re;
               im_d    = sum_im;
               scnt_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge vis_clk or negedge reset_n) begin
      if (!reset_n) begin
         scnt_q      <= '0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         sum_taddr_q <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         taddr_q     <= '0;
         re_q        <= '0;
         im_q        <= '0;
      end else begin
         scnt_q      <= scnt_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         sum_taddr_q <= sum_taddr_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         taddr_q     <= taddr_d;
         re_q        <= re_d;
         im_q        <= im_d;
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign taddr_o = taddr_q;
   assign re_o    = re_q;
   assign im_o    = im_q;

endmodule

// File: tb/tb_sigcorrelate.sv
// Directed bench for sigcorrelate: complex-arithmetic reference model, per-cycle output compare,
// and literal expectations for each scenario.
module tb_sigcorrelate;

   localparam int COUNT = 4;
   localparam int W     = 10; // {taddr, last, re[3:0], im[3:0]}

   logic       vis_clk;
   logic       reset_n;
   logic       valid_i, first_i, last_i;
   logic [0:0] taddr_i;
   logic [3:0] idata_i, qdata_i;
   logic       valid_o, last_o;
   logic [0:0] taddr_o;
   logic [3:0] re_o, im_o;

   sigcorrelate #(
      .WIDTH(4), .TRATE(2), .LOOP0(2), .LOOP1(2),
      .ATAPS(4'b01_00), .BTAPS(4'b10_01)
   ) dut (
      .vis_clk(vis_clk), .reset_n(reset_n),
      .valid_i(valid_i), .first_i(first_i), .last_i(last_i), .taddr_i(taddr_i),
      .idata_i(idata_i), .qdata_i(qdata_i),
      .valid_o(valid_o), .last_o(last_o), .taddr_o(taddr_o), .re_o(re_o), .im_o(im_o)
   );

   // ---------------- clock / cycle count ----------------
   initial vis_clk = 1'b0;
   always #5 vis_clk = ~vis_clk;

   int cyc = 0;
   always @(posedge vis_clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] seen_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: antenna bits as +/-1, product a * conj(b), summed, then mapped to counts.
   int m_cnt = 0;
   int m_re  = 0;
   int m_im  = 0;
   int m_t   = 0;
   int tap_a[2] = '{0, 1};
   int tap_b[2] = '{1, 2};

   function automatic int pm(input logic b);
      return b ? 1 : -1;
   endfunction

   task automatic model_sample(input logic [3:0] id, input logic [3:0] qd, input int t,
                               input logic f, input logic l, input int k);
      int ar, ai, br, bi, pr, pi;
      logic [3:0] re_u, im_u;
      ar = pm(id[tap_a[t]]);
      ai = pm(qd[tap_a[t]]);
      br = pm(id[tap_b[t]]);
      bi = pm(qd[tap_b[t]]);
      pr = ar * br + ai * bi;
      pi = ai * br - ar * bi;
      if (f || m_cnt == 0) begin
         m_cnt = 1;
         m_re  = pr;
         m_im  = pi;
         m_t   = t;
      end else begin
         m_cnt++;
         m_re += pr;
         m_im += pi;
      end
      if (m_cnt == COUNT) begin
         re_u = 4'((m_re + 2 * COUNT) / 2);
         im_u = 4'((m_im + 2 * COUNT) / 2);
         exp_q.push_back({1'(m_t), l, re_u, im_u});
         exp_cyc_q.push_back(k + 2);
         m_cnt = 0;
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge vis_clk) begin
      if (!reset_n) begin
         chk("rst_valid_o", int'(valid_o), 0);
         chk("rst_last_o", int'(last_o), 0);
         chk("rst_taddr_o", int'(taddr_o), 0);
         chk("rst_re_o", int'(re_o), 0);
         chk("rst_im_o", int'(im_o), 0);
      end else begin
         if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            chk("valid_o", int'(valid_o), 1);
            chk("taddr_o", int'(taddr_o), int'(exp_q[0][9]));
            chk("last_o", int'(last_o), int'(exp_q[0][8]));
            chk("re_o", int'(re_o), int'(exp_q[0][7:4]));
            chk("im_o", int'(im_o), int'(exp_q[0][3:0]));
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end else begin
            chk("valid_o_idle", int'(valid_o), 0);
         end
         if (valid_o) seen_q.push_back({taddr_o, last_o, re_o, im_o});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge vis_clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] id, input logic [3:0] qd, input int t,
                       input logic f, input logic l);
      valid_i = 1'b1;
      first_i = f;
      last_i  = l;
      taddr_i = 1'(t);
      idata_i = id;
      qdata_i = qd;
      @(posedge vis_clk);
      #1;
      model_sample(id, qd, t, f, l, cyc);
      valid_i = 1'b0;
      first_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic apply_reset(input int n, input bit rand_inputs);
      reset_n = 1'b0;
      m_cnt = 0;
      exp_q.delete();
      exp_cyc_q.delete();
      repeat (n) begin
         if (rand_inputs) begin
            valid_i = 1'($urandom_range(0, 1));
            first_i = 1'($urandom_range(0, 1));
            last_i  = 1'($urandom_range(0, 1));
            taddr_i = 1'($urandom_range(0, 1));
            idata_i = 4'($urandom_range(0, 15));
            qdata_i = 4'($urandom_range(0, 15));
         end
         @(posedge vis_clk);
         #1;
      end
      valid_i = 1'b0;
      first_i = 1'b0;
      last_i  = 1'b0;
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      valid_i = 1'b0;
      first_i = 1'b0;
      last_i  = 1'b0;
      taddr_i = '0;
      idata_i = '0;
      qdata_i = '0;

      // Reset held with toggling inputs, then idle.
      apply_reset(6, 1'b1);
      idle(6);
      chk("idle_strobes", seen_q.size(), 0);

      // All-ones at t0.
      seen_q.delete();
      send(4'b1111, 4'b1111, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send(4'b1111, 4'b1111, 0, 1'b0, 1'b0);
      idle(4);
      chk("ones_strobes", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("ones_value", int'(seen_q[0]), int'({1'b0, 1'b0, 4'd8, 4'd4}));

      // Mixed bits with 3-cycle gaps.
      seen_q.delete();
      for (int i = 0; i < 4; i++) begin
         send(4'b0001, 4'b0000, 0, 1'(i == 0), 1'b0);
         idle(3);
      end
      idle(2);
      chk("gaps_strobes", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("gaps_value", int'(seen_q[0]), int'({1'b0, 1'b0, 4'd4, 4'd8}));

      // Mid-sum restart: samples 1-2 discarded by first on sample 3.
      seen_q.delete();
      send(4'b1111, 4'b1111, 0, 1'b1, 1'b0);
      send(4'b1111, 4'b1111, 0, 1'b0, 1'b0);
      send(4'b0001, 4'b0000, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send(4'b0001, 4'b0000, 0, 1'b0, 1'b0);
      idle(4);
      chk("restart_strobes", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("restart_value", int'(seen_q[0]), int'({1'b0, 1'b0, 4'd4, 4'd8}));

      // Full frame: t0 then t1, last on sample 8.
      seen_q.delete();
      for (int i = 0; i < 8; i++)
         send(4'b0110, 4'b1010, (i < 4) ? 0 : 1, 1'(i == 0), 1'(i == 7));
      idle(4);
      chk("frame_strobes", seen_q.size(), 2);
      if (seen_q.size() > 1) begin
         chk("frame_sum0", int'(seen_q[0]), int'({1'b0, 1'b0, 4'd0, 4'd4}));
         chk("frame_sum1", int'(seen_q[1]), int'({1'b1, 1'b1, 4'd4, 4'd8}));
      end

      // Reset mid-sum, then a clean sum without first_i.
      seen_q.delete();
      send(4'b1111, 4'b1111, 0, 1'b1, 1'b0);
      send(4'b1111, 4'b1111, 0, 1'b0, 1'b0);
      apply_reset(2, 1'b0);
      idle(5);
      chk("rst_mid_strobes", seen_q.size(), 0);
      for (int i = 0; i < 4; i++) send(4'b0010, 4'b0001, 0, 1'b0, 1'b0);
      idle(4);
      chk("post_rst_strobes", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("post_rst_value", int'(seen_q[0]), int'({1'b0, 1'b0, 4'd0, 4'd4}));

      idle(4);
      chk("drain_pending", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
